bcd_countdown_timer: RTL
========================

# bcd_countdown_timer

Parametrised countdown timer for the bomb-defuse game, and the successor to the fixed 2:59 cronometer. It counts down a programmable time on `tick_1s` and drives four BCD digits (MM:SS) to the seven-segment display path. It adds pause/resume, runtime preset load, strike penalties with a strike limit, and a low-time warning flag. It sits between the 1 Hz tick generator and the display/game-control FSM.

## Interface
Parameters:
- `INIT_TIME_S`, default 170: reset preset in seconds (2:50). Legal range 0..5999.
- `PENALTY_S`, default 10: seconds removed per strike. Legal range 0..5999.
- `WARN_S`, default 30: the warning flag asserts at or below this remaining time.
- `MAX_STRIKES`, default 3: strike count that detonates immediately. Legal range 1..15.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: level or pulse; IDLE/PAUSED -> RUNNING.
- `pause` in 1: pulse; RUNNING -> PAUSED.
- `game_won` in 1: pulse; freezes the timer (DEFUSED).
- `strike` in 1: one-cycle pulse per wrong action.
- `tick_1s` in 1: one-cycle pulse, 1 Hz.
- `load` in 1: pulse; loads `load_value`. Honoured in IDLE only.
- `load_value` in 13: preset in binary seconds. Values above 5999 clamp to 5999.
- `min_dezena`, `min_unidade`, `seg_dezena`, `seg_unidade` out 4 each: BCD digits of the remaining time.
- `strike_count` out 4: strikes accepted since reset.
- `running` out 1: state == RUNNING.
- `warning` out 1: remaining <= `WARN_S` and state is RUNNING or PAUSED.
- `time_over` out 1: state == EXPIRED.

## Operation
- The internal 13-bit register `remaining` holds binary seconds, maximum 5999 (99:59).
- The digits are a combinational decode of `remaining`:
  - minutes = remaining/60, split into tens and units;
  - seconds = remaining%60, split into tens and units.
- Reset values:
  - `remaining` = `INIT_TIME_S`;
  - state = IDLE;
  - `strike_count` = 0;
  - `running`, `warning` and `time_over` = 0;
  - digits show the `INIT_TIME_S` decode (0,2,5,0 for the default).
- States:
  - **IDLE**: `start` -> RUNNING. `load` writes `remaining`.
  - **RUNNING**:
    - `pause` -> PAUSED.
    - `game_won` -> DEFUSED.
    - Each `tick_1s` decrements `remaining`.
    - Each `strike` increments `strike_count` and subtracts `PENALTY_S`.
  - **PAUSED**:
    - `start` -> RUNNING.
    - `game_won` -> DEFUSED.
    - Ticks are ignored.
    - Strikes are still applied.
  - **DEFUSED**: terminal until reset. `remaining` is frozen.
  - **EXPIRED**: terminal until reset. `remaining` = 0.
- Decrement arithmetic:
  - dec = (tick accepted ? 1 : 0) + (strike accepted ? `PENALTY_S` : 0).
  - If dec >= `remaining`: `remaining` <= 0 and the state goes to EXPIRED. Subtraction saturates at 0 and never wraps.
- Strike limit: the strike that makes `strike_count` == `MAX_STRIKES` goes to EXPIRED and sets `remaining` to 0 in that same cycle. `strike_count` saturates at `MAX_STRIKES`.
- Priority within one cycle, highest first: `reset` > `game_won` > `strike`/`tick_1s` (combined) > `pause` > `start` > `load`.
  - `game_won` with a `strike` in the same cycle: DEFUSED wins, and the strike is not counted.
  - `pause` with a `tick_1s` in RUNNING: the tick is applied, then the state becomes PAUSED.
  - `start` is ignored in DEFUSED and EXPIRED.
- Entering RUNNING with `remaining` == 0 goes to EXPIRED on the first accepted tick, not before it.

## Timing
- Every state, counter and flag update is registered on the `clk` rising edge and visible one cycle after the causing input.
- There is no combinational path from the inputs to the outputs. The digits and flags derive only from registered state.
- `time_over` rises on the cycle after the final tick or strike and holds until reset.
- Asserting `reset` at any point returns all outputs to their reset values asynchronously, mid-count included.

## Structure
- The shared package `timer_pkg` holds:
  - the state enum (IDLE, RUNNING, PAUSED, DEFUSED, EXPIRED);
  - `MAX_TIME_S` = 5999;
  - `TIME_W` = 13.
- The sub-module `sec_to_bcd` performs the combinational conversion: 13-bit seconds in, four 4-bit BCD digits out. It is reused by the score display.

## Test plan
- Reset with the default parameters, `start`, then 170 ticks:
  - the digits step 0250 -> 0249 … -> 0000;
  - `time_over` asserts 1 cycle after the 170th tick;
  - further ticks keep 0000.
- `load_value`=75 in IDLE, then `start`:
  - the digits show 0115;
  - after 45 ticks `warning` asserts at 0030 (remaining=30);
  - `warning` stays clear at 0031.
- RUNNING at remaining=100:
  - a `strike` together with `tick_1s` gives remaining 89 and `strike_count`=1;
  - `pause`, 5 ticks, then a strike gives 79;
  - `start` resumes the countdown.
- Three strikes at remaining=500 (`MAX_STRIKES`=3): after the third, `time_over`=1, the digits read 0000, and `strike_count`=3.
- At remaining=5, a strike with `PENALTY_S`=10 saturates to 0 and gives EXPIRED. There is no wrap to 5995+.
- Mid-count `game_won` at 0142:
  - the digits freeze and ticks, strikes and `start` have no effect;
  - asynchronous `reset` mid-cycle restores 0250 with all flags at 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and limits for the countdown timer and the
// score display seconds-to-BCD path.
package timer_pkg;

   localparam int TIME_W     = 13;
   localparam int MAX_TIME_S = 5999;

   typedef enum logic [2:0] {
      IDLE,
      RUNNING,
      PAUSED,
      DEFUSED,
      EXPIRED
   } state_e;

   function automatic logic [TIME_W-1:0] clamp_time(
      input logic [TIME_W-1:0] t
   );
      return (t > TIME_W'(MAX_TIME_S)) ? TIME_W'(MAX_TIME_S) : t;
   endfunction

endpackage

// File: rtl/sec_to_bcd.sv
// Binary seconds (0..5999) to four BCD digits MM:SS.
// Pure combinational; also used by the score display.
module sec_to_bcd
   import timer_pkg::*;
(
   input  logic [TIME_W-1:0] sec_i,
   output logic [3:0]        min_tens_o,
   output logic [3:0]        min_ones_o,
   output logic [3:0]        sec_tens_o,
   output logic [3:0]        sec_ones_o
);

   logic [TIME_W-1:0] mins;
   logic [TIME_W-1:0] secs;

   assign mins = sec_i / TIME_W'(60);
   assign secs = sec_i % TIME_W'(60);

   assign min_tens_o = 4'(mins / TIME_W'(10));
   assign min_ones_o = 4'(mins % TIME_W'(10));
   assign sec_tens_o = 4'(secs / TIME_W'(10));
   assign sec_ones_o = 4'(secs % TIME_W'(10));

endmodule

// File: rtl/bcd_countdown_timer.sv
// Bomb-game countdown: pause/resume, preset load, strike
// penalties with a strike limit, low-time warning.
module bcd_countdown_timer
   import timer_pkg::*;
#(
   parameter int INIT_TIME_S = 170,
   parameter int PENALTY_S   = 10,
   parameter int WARN_S      = 30,
   parameter int MAX_STRIKES = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              pause,
   input  logic              game_won,
   input  logic              strike,
   input  logic              tick_1s,
   input  logic              load,
   input  logic [TIME_W-1:0] load_value,
   output logic [3:0]        min_dezena,
   output logic [3:0]        min_unidade,
   output logic [3:0]        seg_dezena,
   output logic [3:0]        seg_unidade,
   output logic [3:0]        strike_count,
   output logic              running,
   output logic              warning,
   output logic              time_over
);

   localparam int DEC_W = TIME_W + 1;

   state_e            state_q, state_d;
   logic [TIME_W-1:0] rem_q, rem_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [3:0]        cnt_inc;
   logic [DEC_W-1:0]  dec;
   logic              tick_acc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= TIME_W'(INIT_TIME_S);
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
      end
   end

   // Tick and strike penalty merge into one saturating subtraction.
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      cnt_inc  = cnt_q + 4'd1;
      tick_acc = 1'b0;
      dec      = '0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUNNING;
            end else if (load) begin
               rem_d = clamp_time(load_value);
            end
         end
         RUNNING, PAUSED: begin
            if (game_won) begin
               state_d = DEFUSED;
            end else begin
               tick_acc = tick_1s && (state_q == RUNNING);
               dec = (tick_acc ? DEC_W'(1) : DEC_W'(0))
                   + (strike ? DEC_W'(PENALTY_S) : DEC_W'(0));
               if (strike) begin
                  cnt_d = cnt_inc;
               end
               if (strike && (cnt_inc >= 4'(MAX_STRIKES))) begin
                  rem_d   = '0;
                  state_d = EXPIRED;
               end else if ((dec != '0) && (dec >= {1'b0, rem_q})) begin
                  rem_d   = '0;
                  state_d = EXPIRED;
               end else begin
                  rem_d = rem_q - dec[TIME_W-1:0];
                  if ((state_q == RUNNING) && pause) begin
                     state_d = PAUSED;
                  end else if ((state_q == PAUSED) && start) begin
                     state_d = RUNNING;
                  end
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      running   = (state_q == RUNNING);
      time_over = (state_q == EXPIRED);
      warning   = ((state_q == RUNNING) || (state_q == PAUSED))
                && (rem_q <= TIME_W'(WARN_S));
   end

   assign strike_count = cnt_q;

   sec_to_bcd u_bcd (
      .sec_i      (rem_q),
      .min_tens_o (min_dezena),
      .min_ones_o (min_unidade),
      .sec_tens_o (seg_dezena),
      .sec_ones_o (seg_unidade)
   );

endmodule
